// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel UART receiver for 8N1 frames, LSB first. The rx line is
// oversampled on a shared baud-tick strobe (enb). The start bit is validated
// at mid-bit. Each data bit is sampled at mid-bit. The stop bit is checked
// before the byte is published with a sticky ready flag.
//
// Parameters:
//   OVERSAMPLE : enb ticks per bit period (even, >= 4)
//   DATA_BITS  : data bits per frame
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   enb       in   oversample tick, one clk wide
//   rx        in   serial line, idle high, asynchronous to clk
//   rdy_clr   in   host acknowledge; clears rdy (and overrun)
//   data_out  out  last good received byte
//   rdy       out  byte available, sticky until rdy_clr
//   frame_err out  last completed frame had a stop bit of 0
//   busy      out  receiver is inside a frame (state != IDLE)
//   overrun   out  a good byte arrived while rdy was still set
//
// Optional feature:
//   UART_RX_OVERRUN_EN - when defined, overrun detection is built.
//                        When undefined, overrun is tied to 0.
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_ZERO = TW'(0);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   rx_prev;
  logic [TW-1:0]          tick_cnt;
  logic [IW-1:0]          idx;
  logic [DATA_BITS-1:0]   shift_reg;

  // Two-flop synchroniser for the asynchronous rx line. Both flops preset to
  // the idle level so that reset cannot create a false start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // busy is combinational so it drops on the same edge that returns to IDLE.
  always_comb begin
    busy = (state != IDLE);
  end

  // Receive FSM, bit sampling and host-visible flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_prev   <= 1'b1;
      tick_cnt  <= TICK_ZERO;
      idx       <= IDX_ZERO;
      shift_reg <= '0;
      data_out  <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
      overrun   <= 1'b0;
`endif
    end else begin
      // The acknowledge acts on any clock. A stop-bit set later in this
      // block overrides it, so a coinciding set wins.
      if (rdy_clr) begin
        rdy     <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
        overrun <= 1'b0;
`endif
      end

      if (enb) begin
        rx_prev <= rx_s;

        case (state)
          IDLE: begin
            // Only a high-to-low transition starts a frame. A line that is
            // held low must return high before it can start another frame.
            if (rx_prev && !rx_s) begin
              state    <= START;
              tick_cnt <= TICK_ZERO;
            end
          end

          START: begin
            if (tick_cnt == TICK_HALF) begin
              if (!rx_s) begin
                state    <= DATA;
                tick_cnt <= TICK_ZERO;
                idx      <= IDX_ZERO;
              end else begin
                // The line went high before mid-bit: treat it as a glitch.
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end

          DATA: begin
            // The count starts at the middle of the start bit, so every wrap
            // lands on the middle of a data bit.
            if (tick_cnt == TICK_LAST) begin
              tick_cnt       <= TICK_ZERO;
              shift_reg[idx] <= rx_s;
              if (idx == IDX_LAST) begin
                state <= STOP;
              end else begin
                idx <= idx + IDX_ONE;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end

          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              // Returning to IDLE at mid-stop-bit leaves half a bit in which
              // to see the next start edge, so back-to-back frames work.
              state <= IDLE;
              if (rx_s) begin
`ifdef UART_RX_OVERRUN_EN
                if (rdy && !rdy_clr) begin
                  overrun <= 1'b1;
                end
`endif
                data_out  <= shift_reg;
                rdy       <= 1'b1;
                frame_err <= 1'b0;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_ONE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifndef UART_RX_OVERRUN_EN
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//
// Self-checking bench for uart_receiver (OVERSAMPLE=16, DATA_BITS=8).
// enb pulses once every 4 clocks. A fixed table of frames is applied first.
// Hand-written sequences follow for latency, set-vs-clear, glitch,
// held-low framing error and mid-frame reset. The last part is a randomised
// run checked against a frame-level model.
// Build with UART_RX_OVERRUN_EN defined to expect overrun behaviour.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

`ifdef UART_RX_OVERRUN_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       enb;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] data_out;
  logic       rdy;
  logic       frame_err;
  logic       busy;
  logic       overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data_out  (data_out),
    .rdy       (rdy),
    .frame_err (frame_err),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    logic       clr;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_fe;
    logic       e_ov;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One oversample tick; returns at the negedge after the tick edge.
  task automatic tick();
    repeat (3) @(negedge clk);
    enb = 1'b1;
    @(negedge clk);
    enb = 1'b0;
  endtask

  task automatic send_bits(input logic val, input int n);
    rx = val;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_ticks);
    send_bits(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bits(d[i], 16);
    send_bits(stop, stop_ticks);
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
  endtask

  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_fe;
  logic       m_ov;
  logic [7:0] rd;
  logic       good;
  logic       prev_bad;
  int         gap;

  initial begin
    rst = 1'b1; enb = 1'b0; rx = 1'b1; rdy_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset rdy", 32'(rdy), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    send_bits(1'b1, 4);

    // ---------------- table-driven frames ----------------
    tbl[0] = '{8'hA5, 1'b1, 2, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h55, 1'b0, 0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h12, 1'b1, 2, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h11, 1'b1, 0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h22, 1'b1, 0, 1'b1, 8'h22, 1'b1, 1'b0, OV_EN};
    for (int v = 0; v < 7; v++) begin
      if (tbl[v].gap > 0) send_bits(1'b1, tbl[v].gap);
      send_frame(tbl[v].d, tbl[v].stop, 16);
      check($sformatf("tbl%0d data_out", v), 32'(data_out), 32'(tbl[v].e_data));
      check($sformatf("tbl%0d rdy", v), 32'(rdy), 32'(tbl[v].e_rdy));
      check($sformatf("tbl%0d frame_err", v), 32'(frame_err), 32'(tbl[v].e_fe));
      check($sformatf("tbl%0d overrun", v), 32'(overrun), 32'(tbl[v].e_ov));
      check($sformatf("tbl%0d busy", v), 32'(busy), 32'h0);
      if (tbl[v].clr) begin
        pulse_clr();
        check($sformatf("tbl%0d rdy after clr", v), 32'(rdy), 32'h0);
        check($sformatf("tbl%0d overrun after clr", v), 32'(overrun), 32'h0);
      end
    end

    // ---------------- stop-bit latency ----------------
    send_bits(1'b1, 2);
    send_frame(8'h3C, 1'b1, 8);
    check("latency rdy before stop sample", 32'(rdy), 32'h0);
    check("latency busy before stop sample", 32'(busy), 32'h1);
    check("latency data before stop sample", 32'(data_out), 32'h22);
    tick();
    check("latency rdy at stop sample", 32'(rdy), 32'h1);
    check("latency data at stop sample", 32'(data_out), 32'h3C);
    check("latency busy at stop sample", 32'(busy), 32'h0);
    send_bits(1'b1, 7);

    // ---------------- set wins over coinciding rdy_clr ----------------
    send_frame(8'hA5, 1'b1, 8);
    repeat (3) @(negedge clk);
    enb = 1'b1; rdy_clr = 1'b1;
    @(negedge clk);
    enb = 1'b0; rdy_clr = 1'b0;
    check("set-wins rdy", 32'(rdy), 32'h1);
    check("set-wins data", 32'(data_out), 32'hA5);
    check("set-wins overrun", 32'(overrun), 32'h0);
    send_bits(1'b1, 7);
    pulse_clr();

    // ---------------- start-bit glitch ----------------
    send_bits(1'b0, 4);
    check("glitch busy while low", 32'(busy), 32'h1);
    send_bits(1'b1, 5);
    check("glitch back to idle", 32'(busy), 32'h0);
    check("glitch rdy", 32'(rdy), 32'h0);
    check("glitch data unchanged", 32'(data_out), 32'hA5);
    check("glitch frame_err", 32'(frame_err), 32'h0);
    send_bits(1'b1, 2);
    send_frame(8'h3C, 1'b1, 16);
    check("after glitch data", 32'(data_out), 32'h3C);
    check("after glitch rdy", 32'(rdy), 32'h1);
    pulse_clr();

    // ---------------- framing error, line held low ----------------
    send_frame(8'h55, 1'b0, 16);
    send_bits(1'b0, 48);
    check("ferr frame_err", 32'(frame_err), 32'h1);
    check("ferr rdy", 32'(rdy), 32'h0);
    check("ferr data unchanged", 32'(data_out), 32'h3C);
    check("ferr no restart", 32'(busy), 32'h0);
    send_bits(1'b1, 2);
    send_frame(8'h12, 1'b1, 16);
    check("after ferr data", 32'(data_out), 32'h12);
    check("after ferr rdy", 32'(rdy), 32'h1);
    check("after ferr frame_err", 32'(frame_err), 32'h0);
    pulse_clr();

    // ---------------- reset in the middle of a frame ----------------
    send_bits(1'b1, 2);
    send_bits(1'b0, 16);
    send_bits(1'b1, 16);
    send_bits(1'b0, 16);
    send_bits(1'b0, 16);
    send_bits(1'b0, 16);
    send_bits(1'b0, 8);
    check("pre-reset busy", 32'(busy), 32'h1);
    rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    check("mid-reset data_out", 32'(data_out), 32'h0);
    check("mid-reset rdy", 32'(rdy), 32'h0);
    check("mid-reset frame_err", 32'(frame_err), 32'h0);
    check("mid-reset overrun", 32'(overrun), 32'h0);
    check("mid-reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    send_bits(1'b1, 3);
    send_frame(8'h81, 1'b1, 16);
    check("after reset data", 32'(data_out), 32'h81);
    check("after reset rdy", 32'(rdy), 32'h1);
    pulse_clr();

    // ---------------- randomised frames vs frame-level model ----------------
    m_data = 8'h81; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    prev_bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      gap = $urandom_range(0, 3);
      if (prev_bad && gap == 0) gap = 1;
      if (gap > 0) send_bits(1'b1, gap);
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        m_rdy = 1'b0;
        m_ov  = 1'b0;
      end
      rd   = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(rd, good, 16);
      if (good) begin
        if (OV_EN && m_rdy) m_ov = 1'b1;
        m_data = rd;
        m_rdy  = 1'b1;
        m_fe   = 1'b0;
      end else begin
        m_fe = 1'b1;
      end
      prev_bad = !good;
      check($sformatf("rnd%0d data_out", k), 32'(data_out), 32'(m_data));
      check($sformatf("rnd%0d rdy", k), 32'(rdy), 32'(m_rdy));
      check($sformatf("rnd%0d frame_err", k), 32'(frame_err), 32'(m_fe));
      check($sformatf("rnd%0d overrun", k), 32'(overrun), 32'(m_ov));
      check($sformatf("rnd%0d busy", k), 32'(busy), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
